// File: rtl/sad_mode_select.sv
// sad_mode_select: accumulates a per-mode SAD over one block of residual
// beats. It then runs a one-mode-per-cycle min-search over the enabled modes.
// The search picks the best candidate mode for the downstream decision stage.
module sad_mode_select #(
    parameter int NUM_MODES     = 9,
    parameter int SAMPLE_W      = 9,
    parameter int LANES         = 4,
    parameter int BLOCK_SAMPLES = 16,
    parameter int SAD_W         = 16,
    parameter int MIDX_W        = $clog2(NUM_MODES)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_MODES*LANES*SAMPLE_W-1:0] in_res,
    input  logic [NUM_MODES-1:0]                mode_mask,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_MODES*SAD_W-1:0]          out_sads,
    output logic [MIDX_W-1:0]                   best_mode,
    output logic [SAD_W-1:0]                    best_sad,
    output logic                                none_valid
);

    localparam int BEATS  = BLOCK_SAMPLES / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Lane sum holds LANES magnitudes of up to 2^(SAMPLE_W-1) each.
    localparam int LSUM_W = SAMPLE_W + $clog2(LANES) + 1;
    // One extra bit above the wider operand so the saturation test sees the carry.
    localparam int ADD_W  = ((SAD_W > LSUM_W) ? SAD_W : LSUM_W) + 1;

    localparam logic [SAD_W-1:0]  SAD_MAX  = '1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [MIDX_W-1:0] LAST_IDX = MIDX_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REDUCE,
        DONE
    } state_t;

    state_t                          state_q, state_d;
    logic                            in_ready_q, in_ready_d;
    logic                            out_valid_q, out_valid_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_MODES-1:0]            mask_q, mask_d;
    logic [NUM_MODES-1:0][SAD_W-1:0] acc_q, acc_d;
    logic [MIDX_W-1:0]               idx_q, idx_d;
    logic [SAD_W-1:0]                best_sad_q, best_sad_d;
    logic [MIDX_W-1:0]               best_mode_q, best_mode_d;
    logic                            found_q, found_d;
    logic                            none_valid_q, none_valid_d;

    logic [NUM_MODES-1:0][LSUM_W-1:0] lane_sum;
    logic [NUM_MODES-1:0][SAD_W-1:0]  acc_upd;
    logic [SAMPLE_W-1:0]              sample_c;
    logic [SAMPLE_W-1:0]              mag_c;
    logic [ADD_W-1:0]                 sum_c;
    logic [SAD_W-1:0]                 cur_best_sad;
    logic [MIDX_W-1:0]                cur_best_mode;
    logic                             cur_found;
    logic                             beat_fire;

    // Sum of unsigned magnitudes across the lanes of each mode for the current beat.
    // The most negative residual maps to 2^(SAMPLE_W-1), which still fits unsigned.
    always_comb begin
        lane_sum = '0;
        sample_c = '0;
        mag_c    = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            for (int l = 0; l < LANES; l++) begin
                sample_c    = in_res[(m*LANES+l)*SAMPLE_W +: SAMPLE_W];
                mag_c       = sample_c[SAMPLE_W-1] ? ((~sample_c) + SAMPLE_W'(1)) : sample_c;
                lane_sum[m] = lane_sum[m] + LSUM_W'(mag_c);
            end
        end
    end

    // Candidate accumulator values for an accepted beat. The first beat of a block
    // starts from zero. A saturated mode stays pinned because the addends are never negative.
    always_comb begin
        acc_upd = '0;
        sum_c   = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            sum_c      = ((state_q == ACCUM) ? ADD_W'(acc_q[m]) : '0) + ADD_W'(lane_sum[m]);
            acc_upd[m] = (sum_c > ADD_W'(SAD_MAX)) ? SAD_MAX : sum_c[SAD_W-1:0];
        end
    end

    // Next-state and datapath control for the accumulate / reduce / hold sequence.
    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        best_sad_d    = best_sad_q;
        best_mode_d   = best_mode_q;
        found_d       = found_q;
        none_valid_d  = none_valid_q;
        cur_best_sad  = best_sad_q;
        cur_best_mode = best_mode_q;
        cur_found     = found_q;
        beat_fire     = in_valid && in_ready_q;

        case (state_q)
            IDLE: begin
                if (beat_fire) begin
                    mask_d = mode_mask;
                    acc_d  = acc_upd;
                    cnt_d  = CNT_W'(1);
                    if (BEATS == 1) begin
                        state_d    = REDUCE;
                        in_ready_d = 1'b0;
                        idx_d      = '0;
                        cnt_d      = '0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end

            ACCUM: begin
                if (beat_fire) begin
                    acc_d = acc_upd;
                    if (cnt_q == LAST_CNT) begin
                        state_d    = REDUCE;
                        in_ready_d = 1'b0;
                        idx_d      = '0;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            REDUCE: begin
                // The first search step starts from a clean "nothing found yet" state.
                if (idx_q == '0) begin
                    cur_best_sad  = SAD_MAX;
                    cur_best_mode = '0;
                    cur_found     = 1'b0;
                end
                best_sad_d  = cur_best_sad;
                best_mode_d = cur_best_mode;
                found_d     = cur_found;
                // Strict less-than keeps the lowest index on ties.
                if (mask_q[idx_q] && (!cur_found || (acc_q[idx_q] < cur_best_sad))) begin
                    best_sad_d  = acc_q[idx_q];
                    best_mode_d = idx_q;
                    found_d     = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d      = DONE;
                    out_valid_d  = 1'b1;
                    none_valid_d = !found_d;
                    idx_d        = '0;
                end else begin
                    idx_d = idx_q + MIDX_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers. Reset discards any partially accumulated block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            cnt_q        <= '0;
            mask_q       <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            best_sad_q   <= '0;
            best_mode_q  <= '0;
            found_q      <= 1'b0;
            none_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            best_sad_q   <= best_sad_d;
            best_mode_q  <= best_mode_d;
            found_q      <= found_d;
            none_valid_q <= none_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_sads   = acc_q;
    assign best_mode  = best_mode_q;
    assign best_sad   = best_sad_q;
    assign none_valid = none_valid_q;

endmodule
